// File: rtl/mem_pkg.sv
// Shared types and helpers for the core-memory arbiter: widths, FSM and owner
// encodings, the latched request record and the local access-fault rule.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] WIDTH_B = 3'b000;
  localparam logic [2:0] WIDTH_H = 3'b001;
  localparam logic [2:0] WIDTH_W = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [2:0]      width;
    logic            write;
  } mem_req_t;

  // Illegal width always faults; misalignment faults only when checking is enabled.
  function automatic logic access_fault(input logic [1:0] width,
                                        input logic [1:0] addr_lsb,
                                        input logic       align_check);
    logic is_half;
    logic is_word;
    is_half = ({1'b0, width} == WIDTH_H);
    is_word = ({1'b0, width} == WIDTH_W);
    access_fault = (width == 2'b11) ||
                   (align_check && ((is_half && addr_lsb[0]) ||
                                    (is_word && (addr_lsb != 2'b00))));
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that did not win the previous accepted transaction.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  owner_t last_grant_q;
  owner_t last_grant_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_q == OWN_D) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i && (grant_o != 2'b00)) begin
      last_grant_d = grant_o[0] ? OWN_I : OWN_D;
    end
  end

  // Reset to D so that the very first tie is resolved in favour of fetch.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port byte memory between instruction
// fetch (I) and load/store (D): accept, one access cycle, then hold response.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            i_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] i_rsp_data,
  output logic            i_rsp_fault,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  input  logic [2:0]      d_req_width,
  input  logic            d_req_write,
  output logic            d_rsp_valid,
  input  logic            d_rsp_ready,
  output logic [XLEN-1:0] d_rsp_data,
  output logic            d_rsp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_width,
  output logic            mem_write_en,
  input  logic [XLEN-1:0] mem_valM,
  input  logic            mem_fault
);

  arb_state_t      state_q, state_d;
  owner_t          owner_q, owner_d;
  mem_req_t        req_q, req_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic [1:0]      grant;
  logic            handshake;
  logic            local_fault;
  logic            unused_width_msb;

  assign unused_width_msb = d_req_width[2];

  rr_arbiter2 u_rr (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .req_i     ({d_req_valid, i_req_valid}),
    .advance_i (handshake),
    .grant_o   (grant)
  );

  assign local_fault = access_fault(req_q.width[1:0], req_q.addr[1:0], ALIGN_CHECK);

  // The memory port simply mirrors the latched request, so it holds between accesses.
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_width = req_q.width;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    rsp_data_d   = rsp_data_q;
    rsp_fault_d  = rsp_fault_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    handshake    = 1'b0;
    mem_write_en = 1'b0;
    case (state_q)
      IDLE: begin
        i_req_ready = grant[0];
        d_req_ready = grant[1];
        if (i_req_valid && grant[0]) begin
          handshake = 1'b1;
          owner_d   = OWN_I;
          req_d     = '{addr: i_req_addr, wdata: '0, width: WIDTH_W, write: 1'b0};
          state_d   = ACCESS;
        end else if (d_req_valid && grant[1]) begin
          handshake = 1'b1;
          owner_d   = OWN_D;
          req_d     = '{addr: d_req_addr, wdata: d_req_wdata,
                        width: {1'b0, d_req_width[1:0]}, write: d_req_write};
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        mem_write_en = req_q.write && !local_fault;
        rsp_fault_d  = local_fault || mem_fault;
        rsp_data_d   = (req_q.write || rsp_fault_d) ? '0 : mem_valM;
        state_d      = RESPOND;
      end
      RESPOND: begin
        if ((owner_q == OWN_I && i_rsp_ready) || (owner_q == OWN_D && d_rsp_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      req_q       <= '{addr: '0, wdata: '0, width: WIDTH_W, write: 1'b0};
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign i_rsp_valid = (state_q == RESPOND) && (owner_q == OWN_I);
  assign d_rsp_valid = (state_q == RESPOND) && (owner_q == OWN_D);
  assign i_rsp_data  = (owner_q == OWN_I) ? rsp_data_q : '0;
  assign d_rsp_data  = (owner_q == OWN_D) ? rsp_data_q : '0;
  assign i_rsp_fault = (owner_q == OWN_I) && rsp_fault_q;
  assign d_rsp_fault = (owner_q == OWN_D) && rsp_fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model, reference model feeding per-owner
// response queues, and directed fetch/load/store/contention/reset sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int MEM_BYTES = 1024;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_fault;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_write, d_rsp_valid, d_rsp_ready, d_rsp_fault;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [2:0]  d_req_width;
  logic [31:0] mem_addr, mem_wdata, mem_valM;
  logic [2:0]  mem_width;
  logic        mem_write_en, mem_fault;

  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        bd_fill;
  int          wr_cnt;
  logic [2:0]  wr_width;

  exp_t        i_q[$];
  exp_t        d_q[$];
  bit          grant_log[$];
  int          checks;
  int          errors;

  mem_arbiter #(.ALIGN_CHECK(1'b1)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_rsp_valid  (i_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .i_rsp_data   (i_rsp_data),
    .i_rsp_fault  (i_rsp_fault),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_width  (d_req_width),
    .d_req_write  (d_req_write),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_ready  (d_rsp_ready),
    .d_rsp_data   (d_rsp_data),
    .d_rsp_fault  (d_rsp_fault),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_width    (mem_width),
    .mem_write_en (mem_write_en),
    .mem_valM     (mem_valM),
    .mem_fault    (mem_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] fill_byte(input int k);
    case (k)
      16'h10:  fill_byte = 8'hEF;
      16'h11:  fill_byte = 8'hBE;
      16'h12:  fill_byte = 8'hAD;
      16'h13:  fill_byte = 8'hDE;
      default: fill_byte = 8'(k * 7 + 3);
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] w);
    case (w[1:0])
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      default: nbytes = 4;
    endcase
  endfunction

  // Core memory: combinational zero-extended read, write on the clock edge.
  always_comb begin
    mem_fault = 1'b0;
    mem_valM  = '0;
    if (mem_width[1:0] == 2'b11 ||
        ({1'b0, mem_addr} + 33'(nbytes(mem_width))) > 33'(MEM_BYTES)) begin
      mem_fault = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k < nbytes(mem_width)) mem_valM[8*k +: 8] = mem[10'(mem_addr + 32'(k))];
      end
    end
  end

  always @(posedge clock) begin
    if (bd_fill) begin
      for (int k = 0; k < MEM_BYTES; k++) mem[k] <= fill_byte(k);
    end else if (mem_write_en && !mem_fault) begin
      for (int k = 0; k < 4; k++) begin
        if (k < nbytes(mem_width)) mem[10'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
      end
    end
  end

  always @(posedge clock) begin
    if (mem_write_en) begin
      wr_cnt   <= wr_cnt + 1;
      wr_width <= mem_width;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_access(input logic wr, input logic [2:0] w, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] data,
                            output logic flt);
    int  nb;
    logic lf, mf;
    nb = nbytes(w);
    lf = (w[1:0] == 2'b11) || (w[1:0] == 2'b01 && a[0]) || (w[1:0] == 2'b10 && a[1:0] != 2'b00);
    mf = (w[1:0] == 2'b11) || (({1'b0, a} + 33'(nb)) > 33'(MEM_BYTES));
    flt  = lf || mf;
    data = '0;
    if (!flt) begin
      for (int k = 0; k < nb; k++) begin
        if (wr) ref_mem[10'(a + 32'(k))] = wd[8*k +: 8];
        else    data[8*k +: 8] = ref_mem[10'(a + 32'(k))];
      end
    end
  endtask

  // Present a request, wait (bounded) for ready, push the expected response.
  task automatic issue(input bit own_d, input logic wr, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] wd, output int waited);
    exp_t e;
    logic rdy;
    if (own_d) begin
      d_req_valid = 1'b1; d_req_write = wr; d_req_width = w; d_req_addr = a; d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1; i_req_addr = a;
    end
    #1;
    waited = 0;
    rdy = own_d ? d_req_ready : i_req_ready;
    while (!rdy && waited < 40) begin
      @(posedge clock); #1;
      waited++;
      rdy = own_d ? d_req_ready : i_req_ready;
    end
    if (!rdy) begin
      check(own_d ? "d_req_timeout" : "i_req_timeout", 32'(rdy), 32'd1);
      if (own_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
      return;
    end
    if (own_d) ref_access(wr, w, a, wd, e.data, e.fault);
    else       ref_access(1'b0, WIDTH_W, a, 32'h0, e.data, e.fault);
    if (own_d) d_q.push_back(e); else i_q.push_back(e);
    grant_log.push_back(own_d);
    @(posedge clock); #1;
    if (own_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
  endtask

  // Called one cycle after the handshake; pops and compares the response.
  task automatic complete(input bit own_d, input int hold);
    exp_t  e;
    string p;
    p = own_d ? "d" : "i";
    check({p, "_valid_in_access"}, 32'(own_d ? d_rsp_valid : i_rsp_valid), 32'd0);
    @(posedge clock); #1;
    check({p, "_rsp_valid"}, 32'(own_d ? d_rsp_valid : i_rsp_valid), 32'd1);
    check({p, "_other_valid"}, 32'(own_d ? i_rsp_valid : d_rsp_valid), 32'd0);
    if ((own_d ? d_q.size() : i_q.size()) == 0) begin
      check({p, "_sb_empty"}, 32'd1, 32'd0);
      e.data = '0; e.fault = 1'b0;
    end else begin
      e = own_d ? d_q.pop_front() : i_q.pop_front();
    end
    check({p, "_rsp_data"}, own_d ? d_rsp_data : i_rsp_data, e.data);
    check({p, "_rsp_fault"}, 32'(own_d ? d_rsp_fault : i_rsp_fault), 32'(e.fault));
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      check({p, "_hold_valid"}, 32'(own_d ? d_rsp_valid : i_rsp_valid), 32'd1);
      check({p, "_hold_data"}, own_d ? d_rsp_data : i_rsp_data, e.data);
      check({p, "_hold_fault"}, 32'(own_d ? d_rsp_fault : i_rsp_fault), 32'(e.fault));
      check("hold_i_req_ready", 32'(i_req_ready), 32'd0);
      check("hold_d_req_ready", 32'(d_req_ready), 32'd0);
    end
    if (own_d) d_rsp_ready = 1'b1; else i_rsp_ready = 1'b1;
    @(posedge clock); #1;
    if (own_d) d_rsp_ready = 1'b0; else i_rsp_ready = 1'b0;
  endtask

  initial begin
    int         wt;
    int         c0;
    logic [7:0] saved [4];

    checks = 0; errors = 0;
    reset_n = 1'b0; bd_fill = 1'b1;
    i_req_valid = 0; i_req_addr = 0; i_rsp_ready = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_wdata = 0; d_req_width = 0; d_req_write = 0;
    d_rsp_ready = 0;
    for (int k = 0; k < MEM_BYTES; k++) ref_mem[k] = fill_byte(k);
    repeat (2) @(posedge clock);
    #1; bd_fill = 1'b0;

    check("rst_i_rsp_valid", 32'(i_rsp_valid), 0);
    check("rst_d_rsp_valid", 32'(d_rsp_valid), 0);
    check("rst_i_req_ready", 32'(i_req_ready), 0);
    check("rst_d_req_ready", 32'(d_req_ready), 0);
    check("rst_rsp_fault", 32'({i_rsp_fault, d_rsp_fault}), 0);
    check("rst_rsp_data", i_rsp_data | d_rsp_data, 0);
    check("rst_mem_we", 32'(mem_write_en), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_width", 32'(mem_width), 32'(3'b010));
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Fetch 0x10 -> DEADBEEF
    issue(1'b0, 1'b0, WIDTH_W, 32'h10, 32'h0, wt);
    check("i_ready_same_cycle", 32'(wt), 0);
    complete(1'b0, 0);
    $display("txn fetch 0x10 done");

    // Byte store then word load of the containing word
    c0 = wr_cnt;
    issue(1'b1, 1'b1, WIDTH_B, 32'h21, 32'h000000A5, wt);
    complete(1'b1, 0);
    check("sb_write_pulses", 32'(wr_cnt), 32'(c0 + 1));
    check("sb_write_width", 32'(wr_width), 32'(3'b000));
    $display("txn store byte 0x21 done");
    issue(1'b1, 1'b0, WIDTH_W, 32'h20, 32'h0, wt);
    complete(1'b1, 0);
    check("lw_no_write", 32'(wr_cnt), 32'(c0 + 1));
    $display("txn load word 0x20 done");

    // Contention: both requesters hold valid for 4 transactions each
    grant_log.delete();
    fork
      begin
        int wi;
        for (int k = 0; k < 4; k++) begin
          issue(1'b0, 1'b0, WIDTH_W, 32'h100 + 32'(4 * k), 32'h0, wi);
          if (k > 0) check("i_wait_bound", 32'(wi <= 4), 1);
          complete(1'b0, 0);
        end
      end
      begin
        int wd;
        for (int k = 0; k < 4; k++) begin
          issue(1'b1, 1'b0, WIDTH_W, 32'h200 + 32'(4 * k), 32'h0, wd);
          check("d_wait_bound", 32'(wd <= 4), 1);
          complete(1'b1, 0);
        end
      end
    join
    check("rr_count", 32'(grant_log.size()), 8);
    for (int k = 0; k < grant_log.size() && k < 8; k++) begin
      check("rr_order", 32'(grant_log[k]), 32'(k % 2));
    end
    $display("txn contention x8 done");

    // Misaligned word store and illegal width load both fault
    c0 = wr_cnt;
    issue(1'b1, 1'b1, WIDTH_W, 32'h22, 32'hCAFEBABE, wt);
    complete(1'b1, 0);
    $display("txn misaligned store 0x22 done");
    issue(1'b1, 1'b0, 3'b011, 32'h24, 32'h0, wt);
    complete(1'b1, 0);
    $display("txn illegal width load done");
    check("fault_no_write", 32'(wr_cnt), 32'(c0));
    check("mem_0x22_kept", 32'(mem[10'h22]), 32'(ref_mem[10'h22]));

    // Out-of-range load, response held for 5 cycles with fetch pending
    issue(1'b1, 1'b0, WIDTH_W, 32'h400, 32'h0, wt);
    i_req_valid = 1'b1; i_req_addr = 32'h14;
    complete(1'b1, 5);
    issue(1'b0, 1'b0, WIDTH_W, 32'h14, 32'h0, wt);
    check("i_after_hold_wait", 32'(wt), 0);
    complete(1'b0, 0);
    $display("txn out-of-range load + held response done");

    // Reset during the access cycle of a store
    for (int k = 0; k < 4; k++) saved[k] = ref_mem[10'h30 + 10'(k)];
    c0 = wr_cnt;
    issue(1'b1, 1'b1, WIDTH_W, 32'h30, 32'h11223344, wt);
    check("store_we_in_access", 32'(mem_write_en), 1);
    reset_n = 1'b0;
    #1;
    check("arst_mem_we", 32'(mem_write_en), 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_width", 32'(mem_width), 32'(3'b010));
    check("arst_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 0);
    @(posedge clock); #1;
    check("arst_no_write", 32'(wr_cnt), 32'(c0));
    for (int k = 0; k < 4; k++) begin
      ref_mem[10'h30 + 10'(k)] = saved[k];
      check("arst_mem_kept", 32'(mem[10'h30 + 10'(k)]), 32'(saved[k]));
    end
    d_q.delete();
    reset_n = 1'b1;
    @(posedge clock); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_width = WIDTH_W; d_req_addr = 32'h14;
    #1;
    check("post_rst_tie_i", 32'(i_req_ready), 1);
    check("post_rst_tie_d", 32'(d_req_ready), 0);
    issue(1'b0, 1'b0, WIDTH_W, 32'h10, 32'h0, wt);
    complete(1'b0, 0);
    issue(1'b1, 1'b0, WIDTH_W, 32'h14, 32'h0, wt);
    complete(1'b1, 0);
    $display("txn reset during store + post-reset tie done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
